// File: rtl/ptmch_trg_cnt_array.sv
// ptmch_trg_cnt_array: multi-channel trigger-pulse counter bank.
// Each TRG_PLS line is synchronised, glitch-filtered and edge-detected, then
// counted in a saturating counter with a sticky overflow flag.
// Optional feature macro: PTMCH_CNT_SNAPSHOT_EN enables the SNAP-driven
// snapshot bank; without it SNAP_VALUE mirrors CNT_VALUE and SNAP is ignored.
module ptmch_trg_cnt_array #(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 2
) (
  input  logic                    CLK100M,
  input  logic                    RESET_N,
  input  logic [NUM_CH-1:0]       TRG_PLS,
  input  logic [NUM_CH-1:0]       EDGE_SEL,
  input  logic                    CLR,
  input  logic                    SNAP,
  output logic [NUM_CH*CNT_W-1:0] CNT_VALUE,
  output logic [NUM_CH*CNT_W-1:0] SNAP_VALUE,
  output logic [NUM_CH-1:0]       OVF
);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_out;
  logic [NUM_CH-1:0] win_all_one;
  logic [NUM_CH-1:0] win_all_zero;
  logic [NUM_CH-1:0] filt_q, filt_d;
  logic [NUM_CH-1:0] filt_dly_q, filt_dly_d;
  logic [NUM_CH-1:0] edge_hit;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  // Synchroniser chain: the only crossing point for the async trigger inputs
  always_comb begin
    sync_d[0] = TRG_PLS;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    sync_out = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser register
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  generate
    if (FILT_LEN > 1) begin : g_filt
      localparam int unsigned HIST_N = FILT_LEN - 1;
      logic [NUM_CH-1:0] hist_q [HIST_N];
      logic [NUM_CH-1:0] hist_d [HIST_N];

      // History shift: window = synchroniser output plus HIST_N older samples
      always_comb begin
        hist_d[0] = sync_out;
        for (int unsigned i = 1; i < HIST_N; i++) hist_d[i] = hist_q[i-1];
      end

      // History register
      always_ff @(posedge CLK100M or negedge RESET_N) begin
        if (!RESET_N) begin
          for (int unsigned i = 0; i < HIST_N; i++) hist_q[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < HIST_N; i++) hist_q[i] <= hist_d[i];
        end
      end

      // Window agreement: all samples high or all samples low
      always_comb begin
        win_all_one  = sync_out;
        win_all_zero = ~sync_out;
        for (int unsigned i = 0; i < HIST_N; i++) begin
          win_all_one  = win_all_one & hist_q[i];
          win_all_zero = win_all_zero & ~hist_q[i];
        end
      end
    end else begin : g_nofilt
      // Single-sample window: filtered level simply follows the synchroniser
      always_comb begin
        win_all_one  = sync_out;
        win_all_zero = ~sync_out;
      end
    end
  endgenerate

  // Filtered level loads only on a unanimous window, then delayed copy and edge select
  always_comb begin
    filt_d     = (filt_q | win_all_one) & ~win_all_zero;
    filt_dly_d = filt_q;
    edge_hit   = (EDGE_SEL & ~filt_q & filt_dly_q) | (~EDGE_SEL & filt_q & ~filt_dly_q);
  end

  // Saturating counters and sticky overflow; CLR overrides any same-cycle edge
  always_comb begin
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      ovf_d[ch] = ovf_q[ch];
      if (CLR) begin
        cnt_d[ch] = '0;
        ovf_d[ch] = 1'b0;
      end else if (edge_hit[ch]) begin
        if (cnt_q[ch] == '1) ovf_d[ch] = 1'b1;
        else                 cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  // Filter, edge and counter state
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      filt_q     <= '0;
      filt_dly_q <= '0;
      ovf_q      <= '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_dly_q <= filt_dly_d;
      ovf_q      <= ovf_d;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) cnt_q[ch] <= cnt_d[ch];
    end
  end

  // Pack live counters onto the flat output bus
  always_comb begin
    CNT_VALUE = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) CNT_VALUE[ch*CNT_W +: CNT_W] = cnt_q[ch];
    OVF = ovf_q;
  end

`ifdef PTMCH_CNT_SNAPSHOT_EN
  logic [NUM_CH*CNT_W-1:0] snap_q, snap_d;

  // Snapshot takes the registered counts, i.e. before any same-cycle clear
  always_comb begin
    snap_d = snap_q;
    if (SNAP) snap_d = CNT_VALUE;
  end

  // Snapshot bank register
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) snap_q <= '0;
    else          snap_q <= snap_d;
  end

  // Snapshot output
  always_comb SNAP_VALUE = snap_q;
`else
  logic unused_snap;

  // No snapshot bank: mirror the live counters
  always_comb begin
    SNAP_VALUE  = CNT_VALUE;
    unused_snap = SNAP;
  end
`endif

endmodule
